// File: rtl/photocell_conditioner_if.sv
// Signal bundle between the photocell front end and the queue logic it feeds.
interface photocell_conditioner_if;
  logic       phcOneRaw;
  logic       phcTwoRaw;
  logic       phcOne;
  logic       phcTwo;
  logic [1:0] levels;
  logic [1:0] stuckFlags;

  modport slave (
    input  phcOneRaw,
    input  phcTwoRaw,
    output phcOne,
    output phcTwo,
    output levels,
    output stuckFlags
  );

  modport master (
    output phcOneRaw,
    output phcTwoRaw,
    input  phcOne,
    input  phcTwo,
    input  levels,
    input  stuckFlags
  );
endinterface

// File: rtl/photocell_conditioner.sv
// Two-channel photocell conditioner: synchronize, debounce, rising-edge pulse
// and stuck-high detection, with both channels handled identically and independently.
module photocell_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 500
) (
  input  logic                    clock,
  input  logic                    reset,
  photocell_conditioner_if.slave  phc
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STUCK_SAT = SW'(STUCK_CYCLES);

  logic [1:0]    raw;
  logic [1:0]    meta_q, meta_d;
  logic [1:0]    sync_q, sync_d;
  logic [1:0]    acc_q, acc_d;
  logic [1:0]    pulse_q, pulse_d;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];
  logic [SW-1:0] stuck_cnt_q [2];
  logic [SW-1:0] stuck_cnt_d [2];

  assign raw = {phc.phcTwoRaw, phc.phcOneRaw};

  always_comb begin
    meta_d  = raw;
    sync_d  = meta_q;
    acc_d   = acc_q;
    pulse_d = '0;
    for (int n = 0; n < 2; n++) begin
      deb_cnt_d[n]   = '0;
      stuck_cnt_d[n] = stuck_cnt_q[n];
      // The counting edge that would reach DEBOUNCE_CYCLES toggles instead.
      if (sync_q[n] != acc_q[n]) begin
        if (deb_cnt_q[n] == DEB_LAST) begin
          acc_d[n] = ~acc_q[n];
        end else begin
          deb_cnt_d[n] = deb_cnt_q[n] + DW'(1);
        end
      end
      pulse_d[n] = acc_d[n] & ~acc_q[n];
      if (!acc_q[n]) begin
        stuck_cnt_d[n] = '0;
      end else if (stuck_cnt_q[n] != STUCK_SAT) begin
        stuck_cnt_d[n] = stuck_cnt_q[n] + SW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q      <= '0;
      sync_q      <= '0;
      acc_q       <= '0;
      pulse_q     <= '0;
      deb_cnt_q   <= '{default: '0};
      stuck_cnt_q <= '{default: '0};
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      acc_q       <= acc_d;
      pulse_q     <= pulse_d;
      deb_cnt_q   <= deb_cnt_d;
      stuck_cnt_q <= stuck_cnt_d;
    end
  end

  assign phc.phcOne        = pulse_q[0];
  assign phc.phcTwo        = pulse_q[1];
  assign phc.levels        = acc_q;
  assign phc.stuckFlags[0] = (stuck_cnt_q[0] == STUCK_SAT);
  assign phc.stuckFlags[1] = (stuck_cnt_q[1] == STUCK_SAT);

endmodule

// File: tb/tb_photocell_conditioner.sv
// Directed bench for photocell_conditioner with DEBOUNCE_CYCLES=4, STUCK_CYCLES=10.
module tb_photocell_conditioner;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   pulses;

  photocell_conditioner_if phc_if ();

  photocell_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .STUCK_CYCLES    (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .phc   (phc_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " phcOne"}, 32'(phc_if.phcOne), 32'd0);
    chk({tag, " phcTwo"}, 32'(phc_if.phcTwo), 32'd0);
    chk({tag, " levels"}, 32'(phc_if.levels), 32'd0);
    chk({tag, " stuck"},  32'(phc_if.stuckFlags), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    phc_if.phcOneRaw = 1'b0;
    phc_if.phcTwoRaw = 1'b0;

    // Reset with both raw inputs blocked: outputs zero at once and throughout.
    #2;
    reset = 1'b1;
    phc_if.phcOneRaw = 1'b1;
    phc_if.phcTwoRaw = 1'b1;
    #1;
    chk_all_zero("rst_async");
    for (int i = 0; i < 6; i++) begin
      step();
      chk_all_zero("rst_hold");
    end
    phc_if.phcOneRaw = 1'b0;
    phc_if.phcTwoRaw = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_all_zero("post_rst");

    // Channel one held 20 cycles: accept at m=6, stuck at m=16, single pulse.
    phc_if.phcOneRaw = 1'b1;
    for (int m = 1; m <= 20; m++) begin
      step();
      chk("a_lvl0",  32'(phc_if.levels[0]), 32'(m >= 6));
      chk("a_pulse", 32'(phc_if.phcOne), 32'(m == 6));
      chk("a_stuck", 32'(phc_if.stuckFlags[0]), 32'(m >= 16));
      chk("a_two",   32'(phc_if.phcTwo), 32'd0);
    end
    phc_if.phcOneRaw = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      step();
      chk("a_fall_lvl",   32'(phc_if.levels[0]), 32'(m < 6));
      chk("a_fall_stuck", 32'(phc_if.stuckFlags[0]), 32'(m < 7));
      chk("a_fall_pulse", 32'(phc_if.phcOne), 32'd0);
    end

    // Channel two glitch of 3 cycles: never accepted.
    phc_if.phcTwoRaw = 1'b1;
    for (int m = 1; m <= 3; m++) step();
    phc_if.phcTwoRaw = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      step();
      chk("b_lvl1",  32'(phc_if.levels[1]), 32'd0);
      chk("b_pulse", 32'(phc_if.phcTwo), 32'd0);
    end

    // Both channels rise together: both pulse in the same cycle.
    phc_if.phcOneRaw = 1'b1;
    phc_if.phcTwoRaw = 1'b1;
    for (int m = 1; m <= 8; m++) begin
      step();
      chk("c_levels", 32'(phc_if.levels), (m >= 6) ? 32'd3 : 32'd0);
      chk("c_one",    32'(phc_if.phcOne), 32'(m == 6));
      chk("c_two",    32'(phc_if.phcTwo), 32'(m == 6));
    end
    phc_if.phcOneRaw = 1'b0;
    phc_if.phcTwoRaw = 1'b0;
    for (int m = 1; m <= 8; m++) step();
    chk_all_zero("c_idle");

    // Reset mid-debounce: progress discarded, one pulse after full acceptance.
    phc_if.phcOneRaw = 1'b1;
    step();
    step();
    reset = 1'b1;
    #1;
    chk_all_zero("d_rst");
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("d_rst_pulse", 32'(phc_if.phcOne), 32'd0);
      chk("d_rst_lvl",   32'(phc_if.levels), 32'd0);
    end
    reset = 1'b0;
    for (int m = 1; m <= 10; m++) begin
      step();
      if (phc_if.phcOne) pulses++;
      chk("d_lvl0",  32'(phc_if.levels[0]), 32'(m >= 6));
      chk("d_pulse", 32'(phc_if.phcOne), 32'(m == 6));
    end
    chk("d_pulse_count", 32'(pulses), 32'd1);
    phc_if.phcOneRaw = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/photocell_conditioner.md
PHOTOCELL_CONDITIONER -- requirements
Module: photocell_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning consecutive clock cycles a synchronized photocell level must differ from the accepted level before it is accepted (legal range 1..255).
REQ-002 Parameter STUCK_CYCLES, default 500, meaning consecutive cycles a photocell may stay accepted-high before it is flagged stuck (legal range 1..65535).
REQ-003 clock  input  1  single block clock, the divided system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 phcOneRaw  input  1  raw entrance photocell, asynchronous to clock, 1 = beam blocked.
REQ-006 phcTwoRaw  input  1  raw teller-side photocell, asynchronous to clock, 1 = beam blocked.
REQ-007 phcOne  output  1  one-cycle pulse per accepted blocking event on channel one; drives the queue's phcOne input.
REQ-008 phcTwo  output  1  one-cycle pulse per accepted blocking event on channel two; drives the queue's phcTwo input.
REQ-009 levels  output  2  accepted (debounced) level, bit0 = channel one, bit1 = channel two.
REQ-010 stuckFlags  output  2  bit n = 1 while channel n has been accepted-high for at least STUCK_CYCLES cycles.

Function
REQ-011 Each raw input SHALL pass through a two-flop synchronizer; only the second flop output (sync) is used downstream.
REQ-012 Each channel SHALL keep an accepted level and a debounce counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 Any cycle with sync equal to accepted level SHALL clear the debounce counter.
REQ-014 Any cycle with sync different from accepted level SHALL increment the counter; on the edge where the counter would reach DEBOUNCE_CYCLES the accepted level SHALL toggle and the counter SHALL clear.
REQ-015 Latency: raw change held stable from before edge k SHALL change the accepted level at edge k+1+DEBOUNCE_CYCLES (2 sync edges plus DEBOUNCE_CYCLES-1 further counting edges); with default, 5 edges after the first sampling edge.
REQ-016 A raw disturbance shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change the accepted level nor produce a pulse.
REQ-017 phcOne/phcTwo SHALL be registered and high for exactly the one cycle following the edge at which the corresponding accepted level goes 0->1; no pulse on 1->0.
REQ-018 Channels SHALL be fully independent; simultaneous acceptance on both channels SHALL produce both pulses in the same cycle, with no arbitration or suppression.
REQ-019 Each channel SHALL keep a stuck counter of width clog2(STUCK_CYCLES+1) that increments each cycle the accepted level is 1, saturates at STUCK_CYCLES, and clears on the cycle the accepted level is 0.
REQ-020 stuckFlags[n] SHALL be 1 exactly when the channel-n stuck counter equals STUCK_CYCLES; it SHALL fall on the edge after the accepted level falls.
REQ-021 A stuck channel SHALL emit no further pulses until its accepted level returns to 0 and rises again through debounce.
REQ-022 Counters SHALL never wrap.

Reset
REQ-023 While reset is high, synchronizer flops, accepted levels, all counters, phcOne, phcTwo, levels and stuckFlags SHALL be 0, independent of clock.
REQ-024 Reset asserted mid-debounce or mid-stuck-count SHALL discard progress; after release a still-blocked input SHALL require a full 2+DEBOUNCE_CYCLES-cycle acceptance and SHALL then produce exactly one pulse.
REQ-025 On reset release no pulse SHALL be generated merely because a raw input is already 1 at release; the pulse follows normal debounce acceptance only.

Verification (DEBOUNCE_CYCLES=4, STUCK_CYCLES=10)
REQ-026 Assert reset with both raw inputs 1 -> phcOne, phcTwo, levels, stuckFlags all 0 immediately and throughout reset.
REQ-027 phcOneRaw 0->1 before edge k, held -> levels[0]=1 from edge k+5, phcOne=1 for exactly cycle after edge k+5, phcTwo stays 0.
REQ-028 phcTwoRaw high for 3 cycles then low -> no phcTwo pulse, levels[1] stays 0.
REQ-029 Both raw inputs rise before the same edge -> phcOne and phcTwo pulse in the same single cycle.
REQ-030 phcOneRaw held high 20 cycles -> stuckFlags[0]=1 from 10 cycles after levels[0] rose, one pulse total; raw low -> stuckFlags[0]=0 the edge after levels[0] falls.
REQ-031 phcOneRaw rises, reset pulsed 2 cycles later, raw held -> no pulse before release, then exactly one pulse 5 edges after release.
